// File: rtl/tmon_ctrl.sv
// -----------------------------------------------------------------------------
// tmon_ctrl -- temperature monitor controller
//
// Samples an external sensor on a programmable period, keeps running
// statistics (last, max, min, 4-entry moving average) and classifies the
// latest reading against programmable high/low thresholds. A small command
// interface resets statistics, programs period and thresholds, and reads the
// statistics back through a valid/ready output port.
//
// Handshakes: a transfer happens on a rising edge where the producer's valid
// and the consumer's ready are both 1. The producer holds valid and its data
// stable until that edge. cmd_valid/cmd_ready and out_valid/out_ready follow
// this rule. sample_req/sample_ack is a request/acknowledge pair: sample_req
// stays high until the edge on which the one-cycle sample_ack pulse is seen.
//
// Ports
//   clk          in   clock, all logic on rising edge
//   rst_n        in   synchronous active-low reset
//   cmd_valid    in   command offered
//   cmd_op       in   [3:0] opcode (bit 3 set = no-op)
//   cmd_data     in   [7:0] operand for SET_* commands
//   cmd_ready    out  high only in IDLE
//   sample_req   out  request to sensor
//   sample_ack   in   sensor data valid, one-cycle pulse
//   sample_data  in   [7:0] unsigned sensor reading
//   out_valid    out  out_data valid
//   out_data     out  [7:0] result of an OUT_* command
//   out_ready    in   consumer accepts out_data
//   status       out  [1:0] classification of last sample (0 OK,1 LOW,2 HIGH)
//   overrun      out  sticky: a sample tick was lost
//   fsm_state    out  [1:0] current FSM state (0 IDLE,1 SAMPLE,2 OUTPUT)
//
// Opcodes: 0 RESET, 1 SET_FRQ, 2 SET_HIGH_TEMP, 3 SET_LOW_TEMP,
//          4 OUT_MAX, 5 OUT_MIN, 6 OUT_ADDR (last sample), 7 OUT_AVG,
//          1xxx NOOP.
// -----------------------------------------------------------------------------
module tmon_ctrl #(
   parameter logic [7:0] DEFAULT_PERIOD = 8'd100,
   parameter logic [7:0] DEFAULT_HIGH   = 8'd80,
   parameter logic [7:0] DEFAULT_LOW    = 8'd10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   input  logic [3:0] cmd_op,
   input  logic [7:0] cmd_data,
   output logic       cmd_ready,
   output logic       sample_req,
   input  logic       sample_ack,
   input  logic [7:0] sample_data,
   output logic       out_valid,
   output logic [7:0] out_data,
   input  logic       out_ready,
   output logic [1:0] status,
   output logic       overrun,
   output logic [1:0] fsm_state
);

   localparam logic [3:0] OP_RESET    = 4'd0;
   localparam logic [3:0] OP_SET_FRQ  = 4'd1;
   localparam logic [3:0] OP_SET_HIGH = 4'd2;
   localparam logic [3:0] OP_SET_LOW  = 4'd3;

   localparam logic [1:0] ST_OK   = 2'd0;
   localparam logic [1:0] ST_LOW  = 2'd1;
   localparam logic [1:0] ST_HIGH = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SAMPLE = 2'd1,
      S_OUTPUT = 2'd2
   } state_t;

   state_t     state_q, state_d;

   logic [7:0] period_q;
   logic [7:0] count_q, count_d;
   logic       tick_pend_q, tick_pend_d;
   logic       overrun_q, overrun_d;
   logic [7:0] high_thr_q, low_thr_q;
   logic [7:0] max_q, min_q, last_q;
   logic [7:0] hist0_q, hist1_q, hist2_q, hist3_q;
   logic [1:0] status_q;
   logic [7:0] out_data_q;

   logic       cmd_accept;
   logic       start_sample;
   logic       sample_done;
   logic       do_reset, do_set_frq, do_set_high, do_set_low, do_out;
   logic       tick;
   logic [7:0] avg_val;
   logic [7:0] out_sel;
   logic [1:0] status_new;

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A command offered in IDLE always wins over a pending tick; the tick
   // simply stays pending and is serviced on a later idle cycle.
   always_comb begin
      state_d      = state_q;
      cmd_accept   = 1'b0;
      start_sample = 1'b0;
      sample_done  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               cmd_accept = 1'b1;
               if (!cmd_op[3] && cmd_op[2]) begin
                  state_d = S_OUTPUT;
               end
            end else if (tick_pend_q) begin
               start_sample = 1'b1;
               state_d      = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            if (sample_ack) begin
               sample_done = 1'b1;
               state_d     = S_IDLE;
            end
         end
         S_OUTPUT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign cmd_ready  = (state_q == S_IDLE);
   assign sample_req = (state_q == S_SAMPLE);
   assign out_valid  = (state_q == S_OUTPUT);
   assign fsm_state  = state_q;

   // ---------------------------------------------------------------------------
   // Command decode (only meaningful on the accepting cycle)
   // ---------------------------------------------------------------------------
   always_comb begin
      do_reset    = 1'b0;
      do_set_frq  = 1'b0;
      do_set_high = 1'b0;
      do_set_low  = 1'b0;
      do_out      = 1'b0;
      if (cmd_accept && !cmd_op[3]) begin
         do_reset    = (cmd_op == OP_RESET);
         do_set_frq  = (cmd_op == OP_SET_FRQ);
         do_set_high = (cmd_op == OP_SET_HIGH);
         do_set_low  = (cmd_op == OP_SET_LOW);
         do_out      = cmd_op[2];
      end
   end

   // ---------------------------------------------------------------------------
   // Sample timer
   // ---------------------------------------------------------------------------
   // Period 0 disables ticking and parks the counter at 0.
   assign tick = (period_q != 8'd0) && (count_q == (period_q - 8'd1));

   always_comb begin
      count_d = count_q + 8'd1;
      if (tick || (period_q == 8'd0)) begin
         count_d = 8'd0;
      end
      if (do_set_frq) begin
         count_d = 8'd0;
      end

      // A new tick landing on the cycle the previous one is consumed keeps
      // the pending flag set; SET_FRQ discards anything pending.
      tick_pend_d = tick_pend_q;
      if (start_sample) begin
         tick_pend_d = 1'b0;
      end
      if (tick) begin
         tick_pend_d = 1'b1;
      end
      if (do_set_frq) begin
         tick_pend_d = 1'b0;
      end

      // A tick is lost only when one is already waiting and not being
      // consumed in this same cycle.
      overrun_d = overrun_q;
      if (tick && tick_pend_q && !start_sample) begin
         overrun_d = 1'b1;
      end
      if (do_reset) begin
         overrun_d = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Statistics helpers
   // ---------------------------------------------------------------------------
   // 10-bit sum of the four history entries, truncated divide by 4.
   assign avg_val = 8'(({2'b00, hist0_q} + {2'b00, hist1_q} +
                        {2'b00, hist2_q} + {2'b00, hist3_q}) >> 2);

   always_comb begin
      status_new = ST_OK;
      if (sample_data > high_thr_q) begin
         status_new = ST_HIGH;
      end else if (sample_data < low_thr_q) begin
         status_new = ST_LOW;
      end
   end

   always_comb begin
      out_sel = 8'd0;
      case (cmd_op[1:0])
         2'd0: out_sel = max_q;
         2'd1: out_sel = min_q;
         2'd2: out_sel = last_q;
         2'd3: out_sel = avg_val;
         default: out_sel = 8'd0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         period_q    <= DEFAULT_PERIOD;
         count_q     <= 8'd0;
         tick_pend_q <= 1'b0;
         overrun_q   <= 1'b0;
         high_thr_q  <= DEFAULT_HIGH;
         low_thr_q   <= DEFAULT_LOW;
         max_q       <= 8'h00;
         min_q       <= 8'hFF;
         last_q      <= 8'h00;
         hist0_q     <= 8'h00;
         hist1_q     <= 8'h00;
         hist2_q     <= 8'h00;
         hist3_q     <= 8'h00;
         status_q    <= ST_OK;
         out_data_q  <= 8'h00;
      end else begin
         count_q     <= count_d;
         tick_pend_q <= tick_pend_d;
         overrun_q   <= overrun_d;

         if (do_set_frq) begin
            period_q <= cmd_data;
         end
         if (do_set_high) begin
            high_thr_q <= cmd_data;
         end
         if (do_set_low) begin
            low_thr_q <= cmd_data;
         end

         // Commands are only accepted in IDLE and samples only complete in
         // SAMPLE, so these two never coincide.
         if (do_reset) begin
            max_q    <= 8'h00;
            min_q    <= 8'hFF;
            last_q   <= 8'h00;
            hist0_q  <= 8'h00;
            hist1_q  <= 8'h00;
            hist2_q  <= 8'h00;
            hist3_q  <= 8'h00;
            status_q <= ST_OK;
         end else if (sample_done) begin
            last_q <= sample_data;
            if (sample_data > max_q) begin
               max_q <= sample_data;
            end
            if (sample_data < min_q) begin
               min_q <= sample_data;
            end
            hist0_q  <= sample_data;
            hist1_q  <= hist0_q;
            hist2_q  <= hist1_q;
            hist3_q  <= hist2_q;
            status_q <= status_new;
         end

         if (do_out) begin
            out_data_q <= out_sel;
         end
      end
   end

   assign out_data = out_data_q;
   assign status   = status_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_tmon_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tmon_ctrl -- directed testbench for tmon_ctrl
//
// Linear sequence of directed steps with hand-computed expectations. Inputs
// are driven 1 time unit after a rising edge; outputs are checked at the same
// point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_tmon_ctrl;

   localparam logic [3:0] OP_RESET    = 4'd0;
   localparam logic [3:0] OP_SET_FRQ  = 4'd1;
   localparam logic [3:0] OP_SET_HIGH = 4'd2;
   localparam logic [3:0] OP_SET_LOW  = 4'd3;
   localparam logic [3:0] OP_OUT_MAX  = 4'd4;
   localparam logic [3:0] OP_OUT_MIN  = 4'd5;
   localparam logic [3:0] OP_OUT_ADDR = 4'd6;
   localparam logic [3:0] OP_OUT_AVG  = 4'd7;
   localparam logic [3:0] OP_NOOP     = 4'b1010;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic [3:0] cmd_op;
   logic [7:0] cmd_data;
   logic       cmd_ready;
   logic       sample_req;
   logic       sample_ack;
   logic [7:0] sample_data;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic [1:0] status;
   logic       overrun;
   logic [1:0] fsm_state;

   int checks = 0;
   int errors = 0;

   tmon_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_op      (cmd_op),
      .cmd_data    (cmd_data),
      .cmd_ready   (cmd_ready),
      .sample_req  (sample_req),
      .sample_ack  (sample_ack),
      .sample_data (sample_data),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .status      (status),
      .overrun     (overrun),
      .fsm_state   (fsm_state)
   );

   // ---------------------------------------------------------------------------
   // Clock
   // ---------------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic send_cmd(input logic [3:0] op, input logic [7:0] data);
      chk("cmd_ready_before_cmd", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      step();
      cmd_valid = 1'b0;
      cmd_op    = 4'd0;
      cmd_data  = 8'd0;
   endtask

   task automatic read_out(input logic [3:0] op, input logic [7:0] exp, input string name);
      send_cmd(op, 8'd0);
      chk({name, "_valid"}, out_valid, 1);
      chk(name, out_data, exp);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({name, "_drop"}, out_valid, 0);
   endtask

   // Counts edges until sample_req is seen, bounded.
   task automatic wait_req(output int n);
      n = 0;
      while (sample_req !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk("sample_req_seen", sample_req, 1);
   endtask

   // One sample via a short timer period; ticks are disabled again after.
   task automatic do_sample(input logic [7:0] val);
      int n;
      send_cmd(OP_SET_FRQ, 8'd4);
      wait_req(n);
      sample_ack  = 1'b1;
      sample_data = val;
      step();
      sample_ack  = 1'b0;
      sample_data = 8'd0;
      send_cmd(OP_SET_FRQ, 8'd0);
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      int n;
      int rises;
      logic [7:0] vals [4];
      vals = '{8'd20, 8'd40, 8'd60, 8'd81};

      rst_n       = 1'b0;
      cmd_valid   = 1'b0;
      cmd_op      = 4'd0;
      cmd_data    = 8'd0;
      sample_ack  = 1'b0;
      sample_data = 8'd0;
      out_ready   = 1'b0;

      // Reset state
      step(); step(); step();
      chk("rst_sample_req", sample_req, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_status", status, 2'd0);
      chk("rst_overrun", overrun, 0);
      rst_n = 1'b1;
      step();
      chk("rel_cmd_ready", cmd_ready, 1);
      chk("rel_state", fsm_state, 2'd0);

      // Period 5 sampling with sensor ack one cycle after each request
      send_cmd(OP_SET_FRQ, 8'd5);
      wait_req(n);
      chk("first_req_delay_ge5", (n >= 5 && n <= 6), 1);
      for (int i = 0; i < 4; i++) begin
         step();
         sample_ack  = 1'b1;
         sample_data = vals[i];
         step();
         sample_ack  = 1'b0;
         if (i < 3) begin
            wait_req(n);
            chk("req_spacing_5", n + 2, 5);
         end
      end
      send_cmd(OP_SET_FRQ, 8'd0);
      chk("stat_high_81", status, 2'd2);
      chk("no_overrun", overrun, 0);
      read_out(OP_OUT_AVG, 8'd50, "avg_50");
      read_out(OP_OUT_MAX, 8'd81, "max_81");
      read_out(OP_OUT_MIN, 8'd20, "min_20");
      read_out(OP_OUT_ADDR, 8'd81, "last_81");

      // Threshold boundaries
      send_cmd(OP_SET_HIGH, 8'd50);
      send_cmd(OP_SET_LOW, 8'd30);
      chk("status_not_reeval", status, 2'd2);
      do_sample(8'd25);
      chk("status_25_low", status, 2'd1);
      do_sample(8'd30);
      chk("status_30_ok", status, 2'd0);
      do_sample(8'd50);
      chk("status_50_ok", status, 2'd0);
      do_sample(8'd51);
      chk("status_51_high", status, 2'd2);
      read_out(OP_OUT_AVG, 8'd39, "avg_39");
      read_out(OP_OUT_MIN, 8'd20, "min_keep_20");
      read_out(OP_OUT_MAX, 8'd81, "max_keep_81");

      // RESET command clears statistics
      send_cmd(OP_RESET, 8'd0);
      chk("reset_cmd_state", fsm_state, 2'd0);
      chk("reset_cmd_status", status, 2'd0);
      read_out(OP_OUT_MIN, 8'hFF, "min_after_reset");
      read_out(OP_OUT_MAX, 8'h00, "max_after_reset");
      read_out(OP_OUT_ADDR, 8'h00, "last_after_reset");
      read_out(OP_OUT_AVG, 8'h00, "avg_after_reset");

      // Command and pending tick in the same idle cycle
      send_cmd(OP_SET_FRQ, 8'd3);
      step(); step(); step();
      chk("pend_still_idle", fsm_state, 2'd0);
      cmd_valid = 1'b1;
      cmd_op    = OP_SET_HIGH;
      cmd_data  = 8'd80;
      step();
      cmd_valid = 1'b0;
      chk("cmd_first_idle", fsm_state, 2'd0);
      chk("cmd_first_no_req", sample_req, 0);
      step();
      chk("sample_after_cmd", sample_req, 1);
      sample_ack  = 1'b1;
      sample_data = 8'd99;
      step();
      sample_ack  = 1'b0;
      send_cmd(OP_SET_FRQ, 8'd0);
      chk("status_99_high80", status, 2'd2);
      read_out(OP_OUT_MIN, 8'd99, "min_99");
      read_out(OP_OUT_AVG, 8'd24, "avg_24");

      // No-op opcode
      send_cmd(OP_NOOP, 8'd7);
      chk("noop_idle", fsm_state, 2'd0);
      read_out(OP_OUT_MAX, 8'd99, "max_after_noop");

      // Output stall with period 3: overrun, single follow-up sample
      send_cmd(OP_SET_FRQ, 8'd3);
      send_cmd(OP_OUT_ADDR, 8'd0);
      chk("stall_valid0", out_valid, 1);
      chk("stall_data0", out_data, 8'd99);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("stall_valid", out_valid, 1);
         chk("stall_data", out_data, 8'd99);
      end
      chk("stall_overrun", overrun, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("stall_release", out_valid, 0);
      wait_req(n);
      chk("one_sample_soon", n, 1);
      sample_ack  = 1'b1;
      sample_data = 8'd10;
      step();
      sample_ack  = 1'b0;
      send_cmd(OP_SET_FRQ, 8'd0);
      rises = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (sample_req === 1'b1) rises++;
      end
      chk("no_extra_sample", rises, 0);
      read_out(OP_OUT_ADDR, 8'd10, "last_10");
      send_cmd(OP_RESET, 8'd0);
      chk("overrun_cleared", overrun, 0);

      // Reset in the middle of a sample request
      send_cmd(OP_SET_FRQ, 8'd4);
      wait_req(n);
      rst_n = 1'b0;
      step();
      chk("mid_rst_req", sample_req, 0);
      chk("mid_rst_state", fsm_state, 2'd0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_data", out_data, 8'h00);
      chk("mid_rst_status", status, 2'd0);
      rst_n       = 1'b1;
      sample_ack  = 1'b1;
      sample_data = 8'd200;
      step();
      sample_ack  = 1'b0;
      chk("late_ack_ignored", fsm_state, 2'd0);
      read_out(OP_OUT_MAX, 8'h00, "max_after_rst");
      read_out(OP_OUT_MIN, 8'hFF, "min_after_rst");
      read_out(OP_OUT_ADDR, 8'h00, "last_after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
